bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq_pkg.sv | 24 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, state encoding and decimal-limit helper for the
// sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    // Largest value representable in `digits` decimal digits (10^digits - 1).
    function automatic logic [63:0] bcd_max(input int unsigned digits);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    localparam logic [BCD_DIGIT_W-1:0] Thresh = BCD_DIGIT_W'(BCD_ADJ_THRESH);
    localparam logic [BCD_DIGIT_W-1:0] AddVal = BCD_DIGIT_W'(BCD_ADJ_ADD);

    // 4-bit wrap is intentional: no carry leaves the digit.
    assign digit_o = (digit_i >= Thresh) ? digit_i + AddVal : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter: one correction+shift step per clock,
// result saturates to all nines when the operand exceeds DIGITS decimal digits.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 27,
    parameter int unsigned DIGITS   = 8
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [IN_WIDTH-1:0]           bin_i,
    output logic                          busy_o,
    output logic                          valid_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          ovf_o
);

    localparam int unsigned BcdW  = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CntW  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned ShW   = BcdW + IN_WIDTH;
    localparam logic [63:0] Limit = bcd_max(DIGITS);
    localparam logic [BcdW-1:0] AllNines = {DIGITS{4'd9}};

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [BcdW-1:0]     acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    logic [BcdW-1:0]     acc_adj;
    logic [ShW-1:0]      shift_vec;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Bits pushed past the top digit fall off; only reachable on overflow.
    assign shift_vec = {acc_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    acc_d   = '0;
                    cnt_d   = CntW'(IN_WIDTH - 1);
                    flag_d  = (64'(bin_i) > Limit);
                    state_d = StShift;
                end
            end
            StShift: begin
                {acc_d, bin_d} = shift_vec;
                cnt_d          = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    bcd_d   = flag_q ? AllNines : shift_vec[ShW-1 -: BcdW];
                    ovf_d   = flag_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = (state_q == StShift);
    assign valid_o = valid_q;
    assign bcd_o   = bcd_q;
    assign ovf_o   = ovf_q;

endmodule
